aes_shift_rows_pipe: RTL and testbench

- Pipelined, parametrised ShiftRows/InvShiftRows unit for the AES/Rijndael datapath.
- Performs the forward or inverse row rotation per transfer, selected by a mode bit carried with the data.
- Supports Rijndael block widths Nb = 4, 6 or 8 columns.
- Sits between SubBytes/InvSubBytes and MixColumns/InvMixColumns stages, with a valid/ready handshake, an optional sideband tag and a synchronous flush.

---
 rtl/aes_shift_rows_pipe.sv | 142 ++++++++++++++
 tb/tb_aes_shift_rows_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shift_rows_pipe.sv
// aes_shift_rows_pipe
//   Pipelined ShiftRows / InvShiftRows for Rijndael states of NB = 4, 6 or 8
//   columns. The row rotation is applied combinationally on the input and
//   captured in stage 0; stages 1..STAGES-1 are plain elastic registers.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   flush                 synchronous clear of every stage valid (wins over transfers)
//   in_valid / in_ready   input handshake
//   in_inv                0 = ShiftRows, 1 = InvShiftRows (consumed in stage 0)
//   in_data / in_tag      input state (byte 0 at MSB) and sideband tag
//   out_valid / out_ready output handshake
//   out_data / out_tag    permuted state and its tag, straight from registers
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until that edge; a
// registered output never changes while out_valid && !out_ready.
module aes_shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [32*NB-1:0]   in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("aes_shift_rows_pipe: STAGES must be 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_shift_rows_pipe: TAG_W must be at least 1");
  end

  // Rijndael row offsets; only the 8-column block uses the wider spread.
  function automatic int row_off(input int r);
    int off;
    case (r)
      0:       off = 0;
      1:       off = 1;
      2:       off = (NB == 8) ? 3 : 2;
      default: off = (NB == 8) ? 4 : 3;
    endcase
    return off;
  endfunction

  // s[r][c] lives in byte r + 4c, byte k at bits [W-1-8k -: 8].
  function automatic logic [W-1:0] permute(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] o;
    int           src;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (inv) src = (c - row_off(r) + NB) % NB;
        else     src = (c + row_off(r)) % NB;
        o[W-1-8*(r+4*c) -: 8] = d[W-1-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][W-1:0]     data_q,  data_d;
  logic [STAGES-1:0][TAG_W-1:0] tag_q,   tag_d;
  logic [STAGES-1:0]            stage_ready;
  logic [W-1:0]                 perm_data;
  logic                         in_fire;

  // ready_i = !valid_i || ready_(i+1), unrolled as "out_ready or some stage
  // at or after i is empty" so the chain has no self-referencing vector.
  always_comb begin
    logic all_full;
    all_full    = 1'b1;
    stage_ready = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      all_full       = all_full & valid_q[i];
      stage_ready[i] = out_ready | ~all_full;
    end
  end

  assign in_ready  = stage_ready[0] & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign perm_data = permute(in_data, in_inv);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;

    if (stage_ready[0]) begin
      valid_d[0] = in_fire;
      if (in_fire) begin
        data_d[0] = perm_data;
        tag_d[0]  = in_tag;
      end
    end

    for (int i = 1; i < STAGES; i++) begin
      if (stage_ready[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
          tag_d[i]  = tag_q[i-1];
        end
      end
    end

    // Data registers keep stale contents; only occupancy is cleared.
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Bench for aes_shift_rows_pipe: one NB=4/STAGES=2 instance (a_*) and one
// NB=8/STAGES=3 instance (b_*), each with its own expected queue and monitor.
module tb_aes_shift_rows_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT A: NB=4, STAGES=2 ----------------
  logic         a_flush, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
  logic [127:0] a_in_data, a_out_data;
  logic [3:0]   a_in_tag, a_out_tag;

  aes_shift_rows_pipe #(.NB(4), .STAGES(2), .TAG_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
    .in_data(a_in_data), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag)
  );

  // ---------------- DUT B: NB=8, STAGES=3 ----------------
  logic         b_flush, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
  logic [255:0] b_in_data, b_out_data;
  logic [3:0]   b_in_tag, b_out_tag;

  aes_shift_rows_pipe #(.NB(8), .STAGES(3), .TAG_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
    .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag)
  );

  // ---------------- hand-computed vectors ----------------
  localparam logic [127:0] V0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F0 = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] I0 = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [127:0] V1 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] F1 = 128'h10151a1f14191e13181d12171c11161b;
  localparam logic [127:0] I1 = 128'h101d1a1714111e1b1815121f1c191613;
  localparam logic [127:0] V2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] F2 = 128'hffaa5500bb6611cc7722dd8833ee9944;
  localparam logic [127:0] I2 = 128'hff225588bbee114477aadd00336699cc;

  localparam logic [255:0] BV0 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] BF0 =
    256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;
  localparam logic [255:0] BI0 =
    256'h001d161304011a1708051e1b0c09021f100d060314110a0718150e0b1c19120f;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [127:0] a_exp_q[$];
  logic [3:0]   a_tag_q[$];
  logic [255:0] b_exp_q[$];
  logic [3:0]   b_tag_q[$];
  bit           b_chk_q[$];
  logic [255:0] b_last;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [3:0] tag);
    total++;
    bad++;
    $display("FAIL %s output with empty queue, tag=%h", name, tag);
  endtask

  // ---------------- monitors ----------------
  logic [127:0] a_e;
  logic [3:0]   a_t;
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (a_exp_q.size() == 0) unexpected("a_out", a_out_tag);
      else begin
        a_e = a_exp_q.pop_front();
        a_t = a_tag_q.pop_front();
        check("a_data", 256'(a_out_data), 256'(a_e));
        check("a_tag",  256'(a_out_tag),  256'(a_t));
      end
    end
  end

  logic [255:0] b_e;
  logic [3:0]   b_t;
  bit           b_c;
  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (b_exp_q.size() == 0) unexpected("b_out", b_out_tag);
      else begin
        b_e = b_exp_q.pop_front();
        b_t = b_tag_q.pop_front();
        b_c = b_chk_q.pop_front();
        b_last = b_out_data;
        check("b_tag", 256'(b_out_tag), 256'(b_t));
        if (b_c) check("b_data", b_out_data, b_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [127:0] d, input logic inv, input logic [3:0] tag,
                        input logic [127:0] exp);
    int n;
    n = 0;
    a_in_valid = 1'b1; a_in_inv = inv; a_in_data = d; a_in_tag = tag;
    do begin
      @(negedge clk);
      n++;
    end while (!a_in_ready && n < 200);
    check("a_accept", 256'(a_in_ready), 256'(1));
    if (a_in_ready) begin
      a_exp_q.push_back(exp);
      a_tag_q.push_back(tag);
    end
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic b_send(input logic [255:0] d, input logic inv, input logic [3:0] tag,
                        input logic [255:0] exp, input bit chk);
    int n;
    n = 0;
    b_in_valid = 1'b1; b_in_inv = inv; b_in_data = d; b_in_tag = tag;
    do begin
      @(negedge clk);
      n++;
    end while (!b_in_ready && n < 200);
    check("b_accept", 256'(b_in_ready), 256'(1));
    if (b_in_ready) begin
      b_exp_q.push_back(exp);
      b_tag_q.push_back(tag);
      b_chk_q.push_back(chk);
    end
    step();
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((a_exp_q.size() + b_exp_q.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain", 256'(a_exp_q.size() + b_exp_q.size()), 256'(0));
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [255:0] x;

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_inv = 0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_inv = 0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1;
    b_last = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_valid", 256'(a_out_valid), 256'(0));
    check("rst_a_data",  256'(a_out_data),  256'(0));
    check("rst_a_tag",   256'(a_out_tag),   256'(0));
    check("rst_b_valid", 256'(b_out_valid), 256'(0));
    check("rst_b_data",  b_out_data,        256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_a_in_ready", 256'(a_in_ready), 256'(1));
    check("rst_b_in_ready", 256'(b_in_ready), 256'(1));
    step();

    // NB=4 forward with latency of 2 cycles
    a_send(V0, 1'b0, 4'h1, F0);
    @(negedge clk);
    check("a_lat_c1", 256'(a_out_valid), 256'(0));
    @(negedge clk);
    check("a_lat_c2", 256'(a_out_valid), 256'(1));
    step();

    // Back-to-back stream, mixed modes
    a_send(V0, 1'b1, 4'h2, I0);
    a_send(V1, 1'b0, 4'h3, F1);
    a_send(V1, 1'b1, 4'h4, I1);
    a_send(V2, 1'b0, 4'h5, F2);
    a_send(V2, 1'b1, 4'h6, I2);
    drain();

    // Backpressure: two accepted, third stalls, output held
    a_out_ready = 1'b0;
    a_send(V0, 1'b0, 4'h7, F0);
    a_send(V1, 1'b1, 4'h8, I1);
    fork
      a_send(V2, 1'b0, 4'h9, F2);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready",  256'(a_in_ready),  256'(0));
          check("bp_out_valid", 256'(a_out_valid), 256'(1));
          check("bp_out_data",  256'(a_out_data),  256'(F0));
        end
        step();
        a_out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two states in flight
    a_out_ready = 1'b0;
    a_send(V0, 1'b0, 4'ha, F0);
    a_send(V1, 1'b0, 4'hb, F1);
    a_flush = 1'b1;
    a_in_valid = 1'b1; a_in_inv = 1'b1; a_in_data = V2; a_in_tag = 4'hc;
    @(negedge clk);
    check("flush_in_ready", 256'(a_in_ready), 256'(0));
    step();
    a_flush = 1'b0;
    a_exp_q.delete();
    a_tag_q.delete();
    @(negedge clk);
    check("flush_out_valid",   256'(a_out_valid), 256'(0));
    check("post_flush_ready",  256'(a_in_ready),  256'(1));
    if (a_in_ready) begin
      a_exp_q.push_back(I2);
      a_tag_q.push_back(4'hc);
    end
    step();
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    drain();
    repeat (4) step();

    // NB=8 directed vectors
    b_send(BV0, 1'b0, 4'h1, BF0, 1'b1);
    b_send(BV0, 1'b1, 4'h2, BI0, 1'b1);
    drain();

    // NB=8 random round trip: forward, then feed the result back inverted
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) x[32*i +: 32] = $urandom;
      b_send(x, 1'b0, 4'h3, '0, 1'b0);
      drain();
      check("b_s30_is_byte19", 256'(b_last[231 -: 8]), 256'(x[103 -: 8]));
      b_send(b_last, 1'b1, 4'h4, x, 1'b1);
      drain();
    end

    // Asynchronous reset mid-stream
    b_out_ready = 1'b0;
    b_send(BV0, 1'b0, 4'h5, BF0, 1'b1);
    b_send(BV0, 1'b1, 4'h6, BI0, 1'b1);
    repeat (3) step();
    check("pre_reset_valid", 256'(b_out_valid), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 256'(b_out_valid), 256'(0));
    check("async_rst_data",  b_out_data,        256'(0));
    check("async_rst_tag",   256'(b_out_tag),   256'(0));
    b_exp_q.delete();
    b_tag_q.delete();
    b_chk_q.delete();
    step();
    rst_n = 1'b1;
    b_out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 256'(b_in_ready), 256'(1));
    step();
    b_send(BV0, 1'b1, 4'h7, BI0, 1'b1);
    @(negedge clk);
    check("b_lat_c1", 256'(b_out_valid), 256'(0));
    @(negedge clk);
    check("b_lat_c2", 256'(b_out_valid), 256'(0));
    @(negedge clk);
    check("b_lat_c3", 256'(b_out_valid), 256'(1));
    step();
    drain();
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
